// File: rtl/pbkdf2_block_sequencer.sv
// pbkdf2_block_sequencer
//   Runs one PBKDF2-HMAC-SHA256 (c=1) derivation on a shared HMAC core.
//   On an accepted start the key and salt are latched. The block then
//   launches NUM_BLOCKS HMAC jobs on {key, salt, INT32_BE(i)} for
//   i = 1..NUM_BLOCKS, and packs each digest into dk with T1 in the MSBs.
//   If the core takes too long to answer, the derivation is abandoned with
//   an error pulse.
//
// Ports
//   clk          system clock, rising edge
//   n_rst        asynchronous active-low reset
//   start        derivation request, sampled only in IDLE
//   key          HMAC key, latched on accepted start
//   salt         salt, latched on accepted start
//   busy         high in every state except IDLE
//   done         one-cycle pulse, dk valid
//   error        one-cycle pulse, core timeout, dk invalid
//   dk           derived key {T1,T2,...}, held until the next accepted start
//   hmac_data    {key_q, salt_q, idx} presented to the core
//   hmac_enable  one-cycle job launch pulse to the core
//   hmac_hash    core digest
//   hmac_done    core digest valid
module pbkdf2_block_sequencer #(
    parameter int unsigned KEY_W      = 640,
    parameter int unsigned SALT_W     = 1024,
    parameter int unsigned NUM_BLOCKS = 4,
    parameter int unsigned TIMEOUT    = 4095
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic [KEY_W-1:0]            key,
    input  logic [SALT_W-1:0]           salt,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [256*NUM_BLOCKS-1:0]   dk,
    output logic [KEY_W+SALT_W+31:0]    hmac_data,
    output logic                        hmac_enable,
    input  logic [255:0]                hmac_hash,
    input  logic                        hmac_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [3:0]  LAST_IDX  = 4'(NUM_BLOCKS);
    localparam logic [11:0] TIMER_MAX = 12'(TIMEOUT);

    state_e                      state_q, state_d;
    logic [KEY_W-1:0]            key_q, key_d;
    logic [SALT_W-1:0]           salt_q, salt_d;
    logic [3:0]                  idx_q, idx_d;
    logic [11:0]                 timer_q, timer_d;
    logic [256*NUM_BLOCKS-1:0]   dk_q, dk_d;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            key_q   <= '0;
            salt_q  <= '0;
            idx_q   <= 4'd1;
            timer_q <= '0;
            dk_q    <= '0;
        end else begin
            key_q   <= key_d;
            salt_q  <= salt_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            dk_q    <= dk_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        salt_d  = salt_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        dk_d    = dk_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d   = key;
                    salt_d  = salt;
                    idx_d   = 4'd1;
                    dk_d    = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A digest arriving on the final timer cycle still wins.
                if (hmac_done) begin
                    for (int unsigned b = 0; b < NUM_BLOCKS; b++) begin
                        if (idx_q == 4'(b + 1)) begin
                            dk_d[256*(NUM_BLOCKS-1-b) +: 256] = hmac_hash;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    state_d = S_ERR;
                end else begin
                    timer_d = timer_q + 12'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        busy        = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        hmac_enable = 1'b0;
        case (state_q)
            S_IDLE:  busy        = 1'b0;
            S_ISSUE: hmac_enable = 1'b1;
            S_DONE:  done        = 1'b1;
            S_ERR:   error       = 1'b1;
            default: busy        = 1'b1;
        endcase
    end

    assign dk        = dk_q;
    assign hmac_data = {key_q, salt_q, 28'd0, idx_q};

endmodule

// File: tb/tb_pbkdf2_block_sequencer.sv
module tb_pbkdf2_block_sequencer;

    localparam int KW   = 640;
    localparam int SW   = 1024;
    localparam int DW   = KW + SW + 32;
    localparam int TO_A = 4095;
    localparam int TO_B = 20;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    // Instance A: four blocks, default timeout
    logic              start_a, busy_a, done_a, err_a, en_a, hd_a;
    logic [KW-1:0]     key_a;
    logic [SW-1:0]     salt_a;
    logic [1023:0]     dk_a;
    logic [DW-1:0]     hdata_a;
    logic [255:0]      hash_a;
    // Instance B: single block, short timeout
    logic              start_b, busy_b, done_b, err_b, en_b, hd_b;
    logic [KW-1:0]     key_b;
    logic [SW-1:0]     salt_b;
    logic [255:0]      dk_b;
    logic [DW-1:0]     hdata_b;
    logic [255:0]      hash_b;

    pbkdf2_block_sequencer #(.KEY_W(KW), .SALT_W(SW), .NUM_BLOCKS(4), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .n_rst(n_rst), .start(start_a), .key(key_a), .salt(salt_a),
        .busy(busy_a), .done(done_a), .error(err_a), .dk(dk_a), .hmac_data(hdata_a),
        .hmac_enable(en_a), .hmac_hash(hash_a), .hmac_done(hd_a));

    pbkdf2_block_sequencer #(.KEY_W(KW), .SALT_W(SW), .NUM_BLOCKS(1), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .n_rst(n_rst), .start(start_b), .key(key_b), .salt(salt_b),
        .busy(busy_b), .done(done_b), .error(err_b), .dk(dk_b), .hmac_data(hdata_b),
        .hmac_enable(en_b), .hmac_hash(hash_b), .hmac_done(hd_b));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Core model controls and event logs
    int lat_a = 65, drop_a = 0, lat_b = 7;
    int inj_req_a = 0, inj_ack_a = 0;
    bit pend_a = 0, pend_b = 0;
    int cnt_a = 0, cnt_b = 0;
    logic [DW-1:0] job_a, job_b;
    int en_cyc_a[$], hd_cyc_a[$], dn_cyc_a[$], er_cyc_a[$];
    logic [DW-1:0] en_dat_a[$];
    int en_cyc_b[$], hd_cyc_b[$], dn_cyc_b[$], er_cyc_b[$];
    logic [DW-1:0] en_dat_b[$];

    // Stand-in digest for the HMAC core: any mixing function sensitive to all input bits
    function automatic logic [255:0] digest(input logic [DW-1:0] d);
        logic [1791:0] p;
        logic [255:0]  h;
        p = '0;
        p[DW-1:0] = d;
        h = {8{32'h6a09e667}};
        for (int j = 0; j < 7; j++)
            h = ({h[244:0], h[255:245]} ^ p[j*256 +: 256]) + {8{32'h9e3779b9}};
        return h;
    endfunction

    // PBKDF2 block layout: T_i = H(key || salt || INT32_BE(i)), T1 leftmost
    function automatic logic [1023:0] ref_dk4(input logic [KW-1:0] k, input logic [SW-1:0] s);
        logic [1023:0] r;
        for (int i = 1; i <= 4; i++) r[(4-i)*256 +: 256] = digest({k, s, 32'(i)});
        return r;
    endfunction

    function automatic logic [63:0] sig(input logic [1791:0] v);
        logic [63:0] r = '0;
        for (int j = 0; j < 28; j++) r ^= v[j*64 +: 64];
        return r;
    endfunction

    function automatic logic [KW-1:0] rnd_key();
        logic [KW-1:0] v;
        for (int i = 0; i < KW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [SW-1:0] rnd_salt();
        logic [SW-1:0] v;
        for (int i = 0; i < SW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Core models and monitors, sampled mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        hd_a = 1'b0;
        hd_b = 1'b0;
        if (!n_rst) begin
            pend_a = 0;
            pend_b = 0;
            inj_ack_a = inj_req_a;
        end else begin
            if (en_a) begin
                en_cyc_a.push_back(cyc);
                en_dat_a.push_back(hdata_a);
                if (hdata_a[3:0] != 4'(drop_a)) begin
                    pend_a = 1; cnt_a = lat_a; job_a = hdata_a;
                end
            end else if (pend_a) begin
                cnt_a--;
                if (cnt_a == 0) begin
                    hd_a = 1'b1; hash_a = digest(job_a); pend_a = 0; hd_cyc_a.push_back(cyc);
                end
            end
            if (inj_ack_a != inj_req_a) begin
                hd_a = 1'b1; hash_a = ~hash_a; inj_ack_a = inj_req_a;
            end
            if (done_a) dn_cyc_a.push_back(cyc);
            if (err_a) er_cyc_a.push_back(cyc);

            if (en_b) begin
                en_cyc_b.push_back(cyc);
                en_dat_b.push_back(hdata_b);
                pend_b = 1; cnt_b = lat_b; job_b = hdata_b;
            end else if (pend_b) begin
                cnt_b--;
                if (cnt_b == 0) begin
                    hd_b = 1'b1; hash_b = digest(job_b); pend_b = 0; hd_cyc_b.push_back(cyc);
                end
            end
            if (done_b) dn_cyc_b.push_back(cyc);
            if (err_b) er_cyc_b.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel_b, input logic [KW-1:0] k, input logic [SW-1:0] s);
        if (sel_b) begin key_b = k; salt_b = s; start_b = 1'b1; end
        else begin key_a = k; salt_a = s; start_a = 1'b1; end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Returns in the cycle after the done/error pulse
    task automatic wait_end(input bit sel_b, output bit ok);
        int n0;
        n0 = sel_b ? dn_cyc_b.size() + er_cyc_b.size() : dn_cyc_a.size() + er_cyc_a.size();
        ok = 0;
        for (int b = 0; b < 10000 && !ok; b++) begin
            tick();
            if ((sel_b ? dn_cyc_b.size() + er_cyc_b.size() : dn_cyc_a.size() + er_cyc_a.size()) > n0)
                ok = 1;
        end
    endtask

    task automatic wait_q_a(input bit use_hd, input int n, output bit ok);
        ok = 0;
        for (int b = 0; b < 2000 && !ok; b++) begin
            if ((use_hd ? hd_cyc_a.size() : en_cyc_a.size()) >= n) ok = 1;
            else tick();
        end
    endtask

    task automatic test_reset();
        start_a = 1'b1; start_b = 1'b1; key_a = rnd_key(); salt_a = rnd_salt();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (en_a !== 1'b0 || busy_a !== 1'b0 || en_b !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold en_a=%b busy_a=%b en_b=%b exp 0 0 0", en_a, busy_a, en_b);
            end
        end
        start_a = 1'b0; start_b = 1'b0; n_rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy_a, done_a, err_a, en_a} !== 4'b0) begin
            failures++; $display("FAIL reset_outs got=%b exp=0000", {busy_a, done_a, err_a, en_a});
        end
        checks++;
        if (dk_a !== '0) begin failures++; $display("FAIL reset_dk got=%h exp=0", sig(1792'(dk_a))); end
        checks++;
        if (hdata_a !== DW'(1)) begin
            failures++; $display("FAIL reset_hdata got_sig=%h exp=idx1 only", sig(1792'(hdata_a)));
        end
        checks++;
        if (en_cyc_a.size() != 0) begin failures++; $display("FAIL reset_noen got=%0d exp=0", en_cyc_a.size()); end
    endtask

    task automatic test_basic();
        logic [KW-1:0] k; logic [SW-1:0] s; logic [1023:0] exp;
        int e0, h0, d0, r0, s0; bit ok;
        k = rnd_key(); s = '0; s[SW-1 -: KW] = rnd_key();
        exp = ref_dk4(k, s); lat_a = 65; drop_a = 0;
        e0 = en_cyc_a.size(); h0 = hd_cyc_a.size(); d0 = dn_cyc_a.size(); r0 = er_cyc_a.size(); s0 = cyc;
        pulse_start(0, k, s);
        wait_end(0, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_end got=timeout exp=done"); end
        checks++;
        if (en_cyc_a.size() - e0 != 4) begin failures++; $display("FAIL basic_jobs got=%0d exp=4", en_cyc_a.size() - e0); end
        checks++;
        if (en_cyc_a.size() > e0 && en_cyc_a[e0] != s0 + 2) begin
            failures++; $display("FAIL basic_lat0 got=%0d exp=%0d", en_cyc_a[e0], s0 + 2);
        end
        for (int i = 0; i < 4 && e0 + i < en_cyc_a.size(); i++) begin
            checks++;
            if (en_dat_a[e0+i] !== {k, s, 32'(i+1)}) begin
                failures++; $display("FAIL basic_data%0d got_idx=%0h exp_idx=%0h", i, en_dat_a[e0+i][31:0], i + 1);
            end
            if (i > 0 && h0 + i - 1 < hd_cyc_a.size()) begin
                checks++;
                if (en_cyc_a[e0+i] != hd_cyc_a[h0+i-1] + 1) begin
                    failures++; $display("FAIL basic_lat%0d got=%0d exp=%0d", i, en_cyc_a[e0+i], hd_cyc_a[h0+i-1] + 1);
                end
            end
        end
        checks++;
        if (dn_cyc_a.size() - d0 != 1 || er_cyc_a.size() != r0) begin
            failures++; $display("FAIL basic_pulses got done=%0d err=%0d exp 1 0", dn_cyc_a.size() - d0, er_cyc_a.size() - r0);
        end else if (hd_cyc_a.size() >= h0 + 4) begin
            checks++;
            if (dn_cyc_a[d0] != hd_cyc_a[h0+3] + 1) begin
                failures++; $display("FAIL basic_donelat got=%0d exp=%0d", dn_cyc_a[d0], hd_cyc_a[h0+3] + 1);
            end
        end
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b exp=0", busy_a); end
        checks++;
        if (dk_a !== exp) begin failures++; $display("FAIL basic_dk got=%h exp=%h", sig(1792'(dk_a)), sig(1792'(exp))); end
        repeat (5) tick();
        checks++;
        if (dk_a !== exp) begin failures++; $display("FAIL basic_dkhold got=%h exp=%h", sig(1792'(dk_a)), sig(1792'(exp))); end
    endtask

    task automatic test_start_ignored();
        logic [KW-1:0] k; logic [SW-1:0] s; logic [1023:0] exp;
        int e0, h0, d0; bit ok;
        k = rnd_key(); s = rnd_salt(); exp = ref_dk4(k, s); lat_a = 40; drop_a = 0;
        e0 = en_cyc_a.size(); h0 = hd_cyc_a.size(); d0 = dn_cyc_a.size();
        pulse_start(0, k, s);
        wait_q_a(0, e0 + 2, ok);
        repeat (10) tick();
        pulse_start(0, rnd_key(), rnd_salt());
        repeat (3) tick();
        checks++;
        if (hdata_a !== {k, s, 32'd2}) begin
            failures++; $display("FAIL busy_hdata got_sig=%h exp_sig=%h", sig(1792'(hdata_a)), sig(1792'({k, s, 32'd2})));
        end
        wait_q_a(1, h0 + 4, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL busy_end got=timeout exp=4 digests"); end
        // Now in the DONE cycle: this start must be dropped
        pulse_start(0, rnd_key(), rnd_salt());
        repeat (5) tick();
        checks++;
        if (en_cyc_a.size() - e0 != 4) begin failures++; $display("FAIL busy_jobs got=%0d exp=4", en_cyc_a.size() - e0); end
        for (int i = 0; i < 4 && e0 + i < en_cyc_a.size(); i++) begin
            checks++;
            if (en_dat_a[e0+i] !== {k, s, 32'(i+1)}) begin
                failures++; $display("FAIL busy_data%0d got_sig=%h exp_sig=%h", i, sig(1792'(en_dat_a[e0+i])), sig(1792'({k, s, 32'(i+1)})));
            end
        end
        checks++;
        if (dn_cyc_a.size() - d0 != 1 || busy_a !== 1'b0) begin
            failures++; $display("FAIL busy_done got done=%0d busy=%b exp 1 0", dn_cyc_a.size() - d0, busy_a);
        end
        checks++;
        if (dk_a !== exp) begin failures++; $display("FAIL busy_dk got=%h exp=%h", sig(1792'(dk_a)), sig(1792'(exp))); end
    endtask

    task automatic test_timeout();
        logic [KW-1:0] k; logic [SW-1:0] s;
        int e0, d0, r0; bit ok;
        k = rnd_key(); s = rnd_salt(); lat_a = 65; drop_a = 3;
        e0 = en_cyc_a.size(); d0 = dn_cyc_a.size(); r0 = er_cyc_a.size();
        pulse_start(0, k, s);
        wait_end(0, ok);
        checks++;
        if (!ok || er_cyc_a.size() - r0 != 1 || dn_cyc_a.size() != d0) begin
            failures++; $display("FAIL to_pulse got err=%0d done=%0d exp 1 0", er_cyc_a.size() - r0, dn_cyc_a.size() - d0);
        end
        checks++;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL to_busy got=%b exp=0", busy_a); end
        checks++;
        if (en_cyc_a.size() - e0 != 3) begin failures++; $display("FAIL to_jobs got=%0d exp=3", en_cyc_a.size() - e0); end
        // WAIT spans timer values 0..TIMEOUT after the launch cycle, then one ERR cycle
        if (en_cyc_a.size() >= e0 + 3 && er_cyc_a.size() > r0) begin
            checks++;
            if (er_cyc_a[r0] != en_cyc_a[e0+2] + TO_A + 2) begin
                failures++; $display("FAIL to_cycle got=%0d exp=%0d", er_cyc_a[r0], en_cyc_a[e0+2] + TO_A + 2);
            end
        end
        drop_a = 0;
        inj_req_a++;
        repeat (4) tick();
        checks++;
        if (en_cyc_a.size() - e0 != 3 || dn_cyc_a.size() != d0 || busy_a !== 1'b0) begin
            failures++; $display("FAIL to_stale got jobs=%0d done=%0d busy=%b exp 3 0 0", en_cyc_a.size() - e0, dn_cyc_a.size() - d0, busy_a);
        end
        k = rnd_key(); s = rnd_salt();
        pulse_start(0, k, s);
        wait_end(0, ok);
        checks++;
        if (!ok || dn_cyc_a.size() != d0 + 1 || dk_a !== ref_dk4(k, s)) begin
            failures++; $display("FAIL to_restart got=%h exp=%h", sig(1792'(dk_a)), sig(1792'(ref_dk4(k, s))));
        end
    endtask

    task automatic test_single_block();
        logic [KW-1:0] k; logic [SW-1:0] s;
        int e0, h0, d0, r0, L; bit ok, exp_err;
        for (int c = 0; c < 3; c++) begin
            L = (c == 0) ? 7 : TO_B + c;
            exp_err = (c == 2);
            lat_b = L; k = rnd_key(); s = rnd_salt();
            e0 = en_cyc_b.size(); h0 = hd_cyc_b.size(); d0 = dn_cyc_b.size(); r0 = er_cyc_b.size();
            pulse_start(1, k, s);
            wait_end(1, ok);
            repeat (3) tick();
            checks++;
            if (!ok || en_cyc_b.size() - e0 != 1 || busy_b !== 1'b0) begin
                failures++; $display("FAIL single%0d_jobs got=%0d busy=%b exp 1 0", c, en_cyc_b.size() - e0, busy_b);
            end else begin
                checks++;
                if (en_dat_b[e0] !== {k, s, 32'd1}) begin
                    failures++; $display("FAIL single%0d_data got_sig=%h exp_sig=%h", c, sig(1792'(en_dat_b[e0])), sig(1792'({k, s, 32'd1})));
                end
                checks++;
                if (exp_err) begin
                    if (er_cyc_b.size() - r0 != 1 || dn_cyc_b.size() != d0 || er_cyc_b[er_cyc_b.size()-1] != en_cyc_b[e0] + TO_B + 2) begin
                        failures++; $display("FAIL single%0d_err got err=%0d done=%0d exp 1 0 at %0d", c, er_cyc_b.size() - r0, dn_cyc_b.size() - d0, en_cyc_b[e0] + TO_B + 2);
                    end
                end else if (dn_cyc_b.size() - d0 != 1 || er_cyc_b.size() != r0 || hd_cyc_b.size() <= h0 || dn_cyc_b[d0] != hd_cyc_b[h0] + 1) begin
                    failures++; $display("FAIL single%0d_done got done=%0d err=%0d exp 1 0", c, dn_cyc_b.size() - d0, er_cyc_b.size() - r0);
                end else begin
                    checks++;
                    if (dk_b !== digest({k, s, 32'd1})) begin
                        failures++; $display("FAIL single%0d_dk got=%h exp=%h", c, dk_b, digest({k, s, 32'd1}));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [KW-1:0] k; logic [SW-1:0] s;
        int e1, s0; bit ok;
        k = rnd_key(); s = rnd_salt(); lat_a = 65; drop_a = 0;
        pulse_start(0, k, s);
        wait_q_a(0, en_cyc_a.size() + 2, ok);
        repeat (10) tick();
        n_rst = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b0 || en_a !== 1'b0 || dk_a !== '0 || hdata_a !== DW'(1)) begin
            failures++; $display("FAIL abort_state got busy=%b dk=%h exp 0 0", busy_a, sig(1792'(dk_a)));
        end
        tick(); tick();
        n_rst = 1'b1;
        tick();
        k = rnd_key(); s = rnd_salt();
        e1 = en_cyc_a.size(); s0 = cyc;
        pulse_start(0, k, s);
        wait_end(0, ok);
        checks++;
        if (en_cyc_a.size() - e1 != 4 || en_cyc_a[e1] != s0 + 2 || en_dat_a[e1] !== {k, s, 32'd1}) begin
            failures++; $display("FAIL abort_restart got jobs=%0d first_idx=%0h exp 4 1", en_cyc_a.size() - e1, hdata_a[31:0]);
        end
        checks++;
        if (!ok || dk_a !== ref_dk4(k, s)) begin
            failures++; $display("FAIL abort_dk got=%h exp=%h", sig(1792'(dk_a)), sig(1792'(ref_dk4(k, s))));
        end
    endtask

    initial begin
        n_rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        key_a = '0; salt_a = '0; key_b = '0; salt_b = '0;
        hash_a = '0; hash_b = '0; hd_a = 1'b0; hd_b = 1'b0;
        test_reset();
        test_basic();
        test_start_ignored();
        test_timeout();
        test_single_block();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
